slv_axi_regs: RTL and testbench

SLV_AXI_REGS -- requirements
Module: slv_axi_regs

---
 rtl/slv_axi_regs.sv | 234 +++++++++++++++++++++++
 tb/tb_slv_axi_regs.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_axi_regs.sv
// slv_axi_regs: AXI4-Lite slave exposing four 32-bit read/write registers.
// The write and read channels run independent FSMs. Every handshake output
// is a flop, so no READY depends combinationally on a VALID.
module slv_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] SLV_REGS
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t                              wstate_r;
    rstate_t                              rstate_r;
    logic                                 awready_r;
    logic                                 wready_r;
    logic                                 bvalid_r;
    logic                                 arready_r;
    logic                                 rvalid_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]        rdata_r;
    logic [1:0]                           awidx_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]        wdata_r;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]      wstrb_r;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0]   regs_r;

    logic                                 aw_hs_s;
    logic                                 w_hs_s;
    logic                                 upd_s;
    logic [1:0]                           upd_idx_s;
    logic [C_S_AXI_DATA_WIDTH-1:0]        upd_data_s;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]      upd_strb_s;
    logic                                 unused_s;

    assign aw_hs_s = S_AXI_AWVALID & awready_r;
    assign w_hs_s  = S_AXI_WVALID & wready_r;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Decide whether this edge completes a write and which address/data/strobe it uses.
    always_comb begin
        upd_s      = 1'b0;
        upd_idx_s  = awidx_r;
        upd_data_s = wdata_r;
        upd_strb_s = wstrb_r;
        case (wstate_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    upd_s      = 1'b1;
                    upd_idx_s  = S_AXI_AWADDR[3:2];
                    upd_data_s = S_AXI_WDATA;
                    upd_strb_s = S_AXI_WSTRB;
                end else begin
                    upd_s = 1'b0;
                end
            end
            W_ADDR: begin
                if (w_hs_s) begin
                    upd_s      = 1'b1;
                    upd_data_s = S_AXI_WDATA;
                    upd_strb_s = S_AXI_WSTRB;
                end else begin
                    upd_s = 1'b0;
                end
            end
            W_DATA: begin
                if (aw_hs_s) begin
                    upd_s     = 1'b1;
                    upd_idx_s = S_AXI_AWADDR[3:2];
                end else begin
                    upd_s = 1'b0;
                end
            end
            default: begin
                upd_s = 1'b0;
            end
        endcase
    end

    // Write-channel FSM: captures whichever of AW/W arrives first, then holds BVALID until BREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            awidx_r   <= 2'd0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        wstate_r  <= W_RESP;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b1;
                    end else if (aw_hs_s) begin
                        wstate_r  <= W_ADDR;
                        awidx_r   <= S_AXI_AWADDR[3:2];
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                    end else if (w_hs_s) begin
                        wstate_r  <= W_DATA;
                        wdata_r   <= S_AXI_WDATA;
                        wstrb_r   <= S_AXI_WSTRB;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b0;
                    end else begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (w_hs_s) begin
                        wstate_r <= W_RESP;
                        wready_r <= 1'b0;
                        bvalid_r <= 1'b1;
                    end else begin
                        wready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (aw_hs_s) begin
                        wstate_r  <= W_RESP;
                        awready_r <= 1'b0;
                        bvalid_r  <= 1'b1;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bvalid_r && S_AXI_BREADY) begin
                        wstate_r  <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end else begin
                        bvalid_r <= 1'b1;
                    end
                end
                default: begin
                    wstate_r  <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Register file: byte-lane merge of the completed write into the addressed word.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            regs_r <= '0;
        end else if (upd_s) begin
            for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++) begin
                if (upd_strb_s[k]) begin
                    regs_r[upd_idx_s][8*k +: 8] <= upd_data_s[8*k +: 8];
                end
            end
        end
    end

    // Read-channel FSM: samples the word on the AR handshake (pre-write value on a collision).
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_r) begin
                        rstate_r  <= R_DATA;
                        rdata_r   <= regs_r[S_AXI_ARADDR[3:2]];
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rstate_r  <= R_IDLE;
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end else begin
                        rvalid_r <= 1'b1;
                    end
                end
                default: begin
                    rstate_r  <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign SLV_REGS      = regs_r;

endmodule

// File: tb/tb_slv_axi_regs.sv
// Directed testbench for slv_axi_regs. Inputs change 1 ns after a rising edge
// and outputs are sampled on the falling edge.
module tb_slv_axi_regs;

    logic         ACLK;
    logic         ARESETN;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] SLV_REGS;

    int n_vec = 0;
    int n_bad = 0;

    slv_axi_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .SLV_REGS(SLV_REGS)
    );

    // 100 MHz clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full write with both channels offered together; returns BRESP.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit b_done  = 1'b0;
        bit aw_f, w_f;
        resp = 2'b11;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            @(negedge ACLK);
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_f) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_f)  begin S_AXI_WVALID = 1'b0;  w_done = 1'b1;  end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("wr_addr_data_accepted", {aw_done, w_done}, 2'b11);
        S_AXI_BREADY = 1'b1;
        for (int n = 0; n < 20 && !b_done; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin
                resp = S_AXI_BRESP;
                b_done = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b0;
        chk("wr_bvalid_seen", b_done, 1'b1);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit ar_done = 1'b0;
        bit r_done  = 1'b0;
        bit ar_f;
        d = 32'hxxxxxxxx;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !ar_done; n++) begin
            @(negedge ACLK);
            ar_f = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (ar_f) begin S_AXI_ARVALID = 1'b0; ar_done = 1'b1; end
        end
        S_AXI_ARVALID = 1'b0;
        chk("rd_addr_accepted", ar_done, 1'b1);
        S_AXI_RREADY = 1'b1;
        for (int n = 0; n < 20 && !r_done; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin
                d = S_AXI_RDATA;
                chk("rd_rresp", S_AXI_RRESP, 2'b00);
                r_done = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b0;
        chk("rd_rvalid_seen", r_done, 1'b1);
    endtask

    // One channel three cycles ahead of the other, then 5 cycles of BREADY=0.
    task automatic ordered_write(input bit aw_first, input logic [3:0] a, input logic [31:0] d);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
        if (aw_first) S_AXI_AWVALID = 1'b1;
        else          S_AXI_WVALID  = 1'b1;
        @(negedge ACLK);
        chk("ord_first_ready", aw_first ? S_AXI_AWREADY : S_AXI_WREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge ACLK);
            chk("ord_wait_other_ready", aw_first ? S_AXI_WREADY : S_AXI_AWREADY, 1'b1);
            chk("ord_wait_done_ready", aw_first ? S_AXI_AWREADY : S_AXI_WREADY, 1'b0);
            chk("ord_wait_bvalid", S_AXI_BVALID, 1'b0);
            @(posedge ACLK); #1;
        end
        if (aw_first) S_AXI_WVALID  = 1'b1;
        else          S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge ACLK);
            chk("ord_bp_bvalid", S_AXI_BVALID, 1'b1);
            chk("ord_bp_awready", S_AXI_AWREADY, 1'b0);
            chk("ord_bp_wready", S_AXI_WREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("ord_b_hs_bvalid", S_AXI_BVALID, 1'b1);
        chk("ord_b_hs_bresp", S_AXI_BRESP, 2'b00);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        chk("ord_after_b_bvalid", S_AXI_BVALID, 1'b0);
        chk("ord_after_b_awready", S_AXI_AWREADY, 1'b1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] exp_wr [4];
        exp_wr[0] = 32'h1; exp_wr[1] = 32'h2; exp_wr[2] = 32'h3; exp_wr[3] = 32'h4;

        ARESETN = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("rst_regs", SLV_REGS, 128'h0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rel_before_edge_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("rel_first_edge_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;

        // sequential write / read
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(4 * i), exp_wr[i], 4'hF, resp);
            chk("seq_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), rd);
            chk("seq_read", rd, exp_wr[i]);
        end
        chk("seq_slv_regs", SLV_REGS, 128'h00000004_00000003_00000002_00000001);

        // byte strobes, with an unaligned address into word 1
        axi_write(4'h4, 32'hAABBCCDD, 4'hF, resp);
        axi_write(4'h6, 32'h11223344, 4'h5, resp);
        axi_read(4'h4, rd);
        chk("strb_read", rd, 32'hAA22CC44);

        // AW first, then W first, each with BREADY back-pressure
        ordered_write(1'b1, 4'h8, 32'hDEADBEEF);
        chk("ord_aw_first_reg2", SLV_REGS[95:64], 32'hDEADBEEF);
        axi_write(4'h8, 32'h0, 4'hF, resp);
        chk("ord_clear_reg2", SLV_REGS[95:64], 32'h0);
        ordered_write(1'b0, 4'h8, 32'hDEADBEEF);
        chk("ord_w_first_reg2", SLV_REGS[95:64], 32'hDEADBEEF);

        // simultaneous write and read of the same register
        axi_write(4'h8, 32'h5, 4'hF, resp);
        S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 4'h8;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        chk("sim_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        chk("sim_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        chk("sim_rdata_old", S_AXI_RDATA, 32'h5);
        chk("sim_reg2_new", SLV_REGS[95:64], 32'h9);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(4'h8, rd);
        chk("sim_reread", rd, 32'h9);

        // reset in the middle of a write
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        chk("mid_aw_ready", S_AXI_AWREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("mid_rst_regs", SLV_REGS, 128'h0);
        chk("mid_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("mid_rel_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'h00000077; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge ACLK);
            chk("mid_no_bvalid", S_AXI_BVALID, 1'b0);
            chk("mid_wdata_state", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b10);
            chk("mid_reg0", SLV_REGS[31:0], 32'h0);
            @(posedge ACLK); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
